// File: rtl/frame_pos_ctr_if.sv
// Frame position counter bus: client-side controls plus the decoded position
// and strobes that the counter reports back.
interface frame_pos_ctr_if #(
  parameter int ROWS = 4,
  parameter int COLS = 1041,
  parameter int MF_W = 8
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  // Handshake: a client payload beat transfers on any cycle where valid and
  // ready are both high. In map mode ready drops on overhead columns and the
  // counter moves through them without a client beat. In demap mode valid
  // marks a received beat and ready stays low. adv tells the client that the
  // position will step at the next rising edge.
  logic             enable;
  logic             valid;
  logic             sync;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [MF_W-1:0]  mf;
  logic             adv;
  logic             ready;
  logic             oh;
  logic             sof;
  logic             eof;
  logic             sync_err;

  modport master (
    output enable, valid, sync,
    input  row, col, mf, adv, ready, oh, sof, eof, sync_err
  );

  modport slave (
    input  enable, valid, sync,
    output row, col, mf, adv, ready, oh, sof, eof, sync_err
  );
endinterface

// File: rtl/frame_pos_ctr.sv
// Tracks (row, column, multiframe) inside a framed stream, for either
// transmit mapping (overhead columns self-advance) or receive demapping.
module frame_pos_ctr #(
  parameter int MAP_MODE = 1,
  parameter int ROWS     = 4,
  parameter int COLS     = 1041,
  parameter int OH_COLS  = 16,
  parameter int MF_W     = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  frame_pos_ctr_if.slave bus
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  // A nonsensical geometry or mode parks every output at zero.
  localparam bit CFG_OK = ((MAP_MODE == 0) || (MAP_MODE == 1)) &&
                          (OH_COLS < COLS) && (ROWS >= 2);
  localparam bit IS_MAP = (MAP_MODE == 1);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] OH_LIM   = COL_W'(OH_COLS);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [MF_W-1:0]  mf_q, mf_d;
  logic             sync_err_q, sync_err_d;

  logic oh, sof, eof, adv, ready, sync_hit;

  always_comb begin
    oh       = (col_q < OH_LIM);
    sof      = (row_q == '0) && (col_q == '0);
    eof      = (row_q == LAST_ROW) && (col_q == LAST_COL);
    adv      = IS_MAP ? (bus.enable & (oh | bus.valid)) : (bus.enable & bus.valid);
    ready    = IS_MAP & bus.enable & ~oh;
    sync_hit = ~IS_MAP & bus.enable & bus.valid & bus.sync;

    row_d      = row_q;
    col_d      = col_q;
    mf_d       = mf_q;
    sync_err_d = sync_hit & ~sof;

    // The sync beat itself is (0, 0), so the following beat sits at (0, 1).
    if (sync_hit) begin
      row_d = '0;
      col_d = COL_W'(1);
    end else if (adv) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        if (row_q == LAST_ROW) begin
          row_d = '0;
          mf_d  = mf_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_q      <= '0;
      col_q      <= '0;
      mf_q       <= '0;
      sync_err_q <= 1'b0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      mf_q       <= mf_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.row      = CFG_OK ? row_q : '0;
  assign bus.col      = CFG_OK ? col_q : '0;
  assign bus.mf       = CFG_OK ? mf_q  : '0;
  assign bus.adv      = CFG_OK & adv;
  assign bus.ready    = CFG_OK & ready;
  assign bus.oh       = CFG_OK & oh;
  assign bus.sof      = CFG_OK & sof;
  assign bus.eof      = CFG_OK & eof;
  assign bus.sync_err = CFG_OK & sync_err_q;
endmodule

// File: tb/tb_frame_pos_ctr.sv
// Bench for frame_pos_ctr: demap, map, small-geometry and invalid-config
// instances checked against a linear-position reference model.
module tb_frame_pos_ctr;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  always #5 i_clk = ~i_clk;

  frame_pos_ctr_if #(.ROWS(4), .COLS(1041), .MF_W(8)) ifd ();
  frame_pos_ctr_if #(.ROWS(4), .COLS(1041), .MF_W(8)) ifm ();
  frame_pos_ctr_if #(.ROWS(2), .COLS(4),    .MF_W(8)) ifs ();
  frame_pos_ctr_if #(.ROWS(4), .COLS(8),    .MF_W(8)) ifb ();

  frame_pos_ctr #(.MAP_MODE(0), .ROWS(4), .COLS(1041), .OH_COLS(16), .MF_W(8))
    u_dmp (.i_clk(i_clk), .i_rst(i_rst), .bus(ifd));
  frame_pos_ctr #(.MAP_MODE(1), .ROWS(4), .COLS(1041), .OH_COLS(16), .MF_W(8))
    u_map (.i_clk(i_clk), .i_rst(i_rst), .bus(ifm));
  frame_pos_ctr #(.MAP_MODE(0), .ROWS(2), .COLS(4), .OH_COLS(1), .MF_W(8))
    u_sml (.i_clk(i_clk), .i_rst(i_rst), .bus(ifs));
  frame_pos_ctr #(.MAP_MODE(1), .ROWS(4), .COLS(8), .OH_COLS(8), .MF_W(8))
    u_bad (.i_clk(i_clk), .i_rst(i_rst), .bus(ifb));

  typedef struct packed {
    int row;
    int col;
    int mf;
    int serr;
  } pos_t;

  localparam int PW = $bits(pos_t);

  int c_rows [3] = '{4, 4, 2};
  int c_cols [3] = '{1041, 1041, 4};
  int c_oh   [3] = '{16, 16, 1};
  int c_mfw  [3] = '{8, 8, 8};
  int c_map  [3] = '{0, 1, 0};

  pos_t           m [3];
  logic [PW-1:0]  exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;
  int             last_eof;
  int             eof_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position as a single index into the frame: step by one, wrap the frame.
  function automatic pos_t next_pos(input pos_t p, input int w,
                                    input bit en, input bit v, input bit s);
    pos_t n;
    int   lin;
    bit   is_oh, hit, step;
    is_oh = (p.col < c_oh[w]);
    hit   = (c_map[w] == 0) && en && v && s;
    step  = (c_map[w] != 0) ? (en && (is_oh || v)) : (en && v);
    n      = p;
    n.serr = (hit && !(p.row == 0 && p.col == 0)) ? 1 : 0;
    if (hit) begin
      n.row = 0;
      n.col = 1;
    end else if (step) begin
      lin = p.row * c_cols[w] + p.col + 1;
      if (lin == c_rows[w] * c_cols[w]) begin
        lin  = 0;
        n.mf = (p.mf + 1) % (1 << c_mfw[w]);
      end
      n.row = lin / c_cols[w];
      n.col = lin % c_cols[w];
    end
    return n;
  endfunction

  task automatic drive(input int w, input bit en, input bit v, input bit s);
    ifd.enable = (w == 0) && en; ifd.valid = (w == 0) && v; ifd.sync = (w == 0) && s;
    ifm.enable = (w == 1) && en; ifm.valid = (w == 1) && v; ifm.sync = (w == 1) && s;
    ifs.enable = (w == 2) && en; ifs.valid = (w == 2) && v; ifs.sync = (w == 2) && s;
  endtask

  // One clock of the selected instance; entered and left on a falling edge.
  task automatic cycle(input int w, input bit en, input bit v, input bit s);
    int   o_row, o_col, o_mf, o_serr, o_sof, o_eof, o_oh, o_adv, o_rdy;
    int   e_oh, e_adv, e_rdy, e_sof, e_eof;
    pos_t p;
    if (exp_q.size() > 0) m[w] = pos_t'(exp_q.pop_front());
    p = m[w];
    drive(w, en, v, s);
    #1;
    case (w)
      0: begin
        o_row = int'(ifd.row); o_col = int'(ifd.col); o_mf = int'(ifd.mf);
        o_serr = int'(ifd.sync_err); o_sof = int'(ifd.sof); o_eof = int'(ifd.eof);
        o_oh = int'(ifd.oh); o_adv = int'(ifd.adv); o_rdy = int'(ifd.ready);
      end
      1: begin
        o_row = int'(ifm.row); o_col = int'(ifm.col); o_mf = int'(ifm.mf);
        o_serr = int'(ifm.sync_err); o_sof = int'(ifm.sof); o_eof = int'(ifm.eof);
        o_oh = int'(ifm.oh); o_adv = int'(ifm.adv); o_rdy = int'(ifm.ready);
      end
      default: begin
        o_row = int'(ifs.row); o_col = int'(ifs.col); o_mf = int'(ifs.mf);
        o_serr = int'(ifs.sync_err); o_sof = int'(ifs.sof); o_eof = int'(ifs.eof);
        o_oh = int'(ifs.oh); o_adv = int'(ifs.adv); o_rdy = int'(ifs.ready);
      end
    endcase
    e_oh  = (p.col < c_oh[w]) ? 1 : 0;
    e_sof = (p.row == 0 && p.col == 0) ? 1 : 0;
    e_eof = (p.row == c_rows[w] - 1 && p.col == c_cols[w] - 1) ? 1 : 0;
    if (c_map[w] != 0) begin
      e_adv = (en && (e_oh != 0 || v)) ? 1 : 0;
      e_rdy = (en && e_oh == 0) ? 1 : 0;
    end else begin
      e_adv = (en && v) ? 1 : 0;
      e_rdy = 0;
    end
    check($sformatf("d%0d_row", w),      o_row,  p.row);
    check($sformatf("d%0d_col", w),      o_col,  p.col);
    check($sformatf("d%0d_mf", w),       o_mf,   p.mf);
    check($sformatf("d%0d_sync_err", w), o_serr, p.serr);
    check($sformatf("d%0d_sof", w),      o_sof,  e_sof);
    check($sformatf("d%0d_eof", w),      o_eof,  e_eof);
    check($sformatf("d%0d_oh", w),       o_oh,   e_oh);
    check($sformatf("d%0d_adv", w),      o_adv,  e_adv);
    check($sformatf("d%0d_ready", w),    o_rdy,  e_rdy);
    last_eof = o_eof;
    exp_q.push_back(next_pos(p, w, en, v, s));
    @(negedge i_clk);
  endtask

  // Reset with every input high so reset priority is exercised each time.
  task automatic do_reset();
    i_rst = 1'b1;
    ifd.enable = 1'b1; ifd.valid = 1'b1; ifd.sync = 1'b1;
    ifm.enable = 1'b1; ifm.valid = 1'b1; ifm.sync = 1'b1;
    ifs.enable = 1'b1; ifs.valid = 1'b1; ifs.sync = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(-1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) m[i] = '0;
    exp_q.delete();
  endtask

  task automatic check_bad_cfg();
    check("bad_row", int'(ifb.row), 0);
    check("bad_col", int'(ifb.col), 0);
    check("bad_mf",  int'(ifb.mf),  0);
    check("bad_strobes",
          int'({ifb.adv, ifb.ready, ifb.oh, ifb.sof, ifb.eof, ifb.sync_err}), 0);
  endtask

  initial begin
    drive(-1, 1'b0, 1'b0, 1'b0);
    ifb.enable = 1'b1; ifb.valid = 1'b1; ifb.sync = 1'b0;
    @(negedge i_clk);
    do_reset();
    ifb.enable = 1'b1; ifb.valid = 1'b1;

    // Idle after reset.
    repeat (3) cycle(0, 1'b0, 1'b0, 1'b0);
    check("rst_sof", int'(ifd.sof), 1);
    check("rst_oh",  int'(ifd.oh),  1);
    check("rst_row", int'(ifd.row), 0);
    check_bad_cfg();

    // One full demap frame.
    eof_cnt = 0;
    repeat (4164) begin
      cycle(0, 1'b1, 1'b1, 1'b0);
      eof_cnt += last_eof;
    end
    check("frame_eof_count", eof_cnt, 1);
    check("frame_end_row", int'(ifd.row), 0);
    check("frame_end_col", int'(ifd.col), 0);
    check("frame_end_mf",  int'(ifd.mf),  1);
    check_bad_cfg();

    // Random demap traffic with occasional sync beats.
    for (int i = 0; i < 3000; i++)
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);

    // Misaligned sync at (2, 500), then aligned sync at (0, 0).
    do_reset();
    repeat (2582) cycle(0, 1'b1, 1'b1, 1'b0);
    check("pre_sync_row", int'(ifd.row), 2);
    check("pre_sync_col", int'(ifd.col), 500);
    cycle(0, 1'b1, 1'b1, 1'b1);
    check("sync_row", int'(ifd.row), 0);
    check("sync_col", int'(ifd.col), 1);
    check("sync_err_pulse", int'(ifd.sync_err), 1);
    cycle(0, 1'b0, 1'b0, 1'b0);
    check("sync_err_clear", int'(ifd.sync_err), 0);
    do_reset();
    cycle(0, 1'b1, 1'b1, 1'b1);
    check("aligned_sync_err", int'(ifd.sync_err), 0);
    check("aligned_sync_col", int'(ifd.col), 1);

    // Hold at the row's last column, then reset mid-frame.
    do_reset();
    repeat (2081) cycle(0, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle(0, 1'b0, 1'b1, 1'b0);
    check("hold_row", int'(ifd.row), 1);
    check("hold_col", int'(ifd.col), 1040);
    do_reset();
    repeat (1741) cycle(0, 1'b1, 1'b1, 1'b0);
    check("mid_row", int'(ifd.row), 1);
    check("mid_col", int'(ifd.col), 700);
    do_reset();
    check("mid_rst_col", int'(ifd.col), 0);
    check("mid_rst_mf",  int'(ifd.mf),  0);
    repeat (2) cycle(0, 1'b0, 1'b0, 1'b0);

    // Map: overhead self-advances, payload waits for the client.
    do_reset();
    repeat (16) cycle(1, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1, 1'b1, 1'b0, 1'b0);
    check("map_stall_col",   int'(ifm.col),   16);
    check("map_stall_ready", int'(ifm.ready), 1);
    check("map_stall_adv",   int'(ifm.adv),   0);
    cycle(1, 1'b1, 1'b1, 1'b0);
    check("map_resume_col", int'(ifm.col), 17);
    for (int i = 0; i < 3000; i++)
      cycle(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 7) == 0);

    // Small geometry: multiframe wrap after 256 frames.
    do_reset();
    repeat (8) cycle(2, 1'b1, 1'b1, 1'b0);
    check("sml_mf_one", int'(ifs.mf), 1);
    repeat (2040) cycle(2, 1'b1, 1'b1, 1'b0);
    check("sml_mf_wrap", int'(ifs.mf), 0);
    check("sml_wrap_col", int'(ifs.col), 0);
    for (int i = 0; i < 1000; i++)
      cycle(2, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
    check_bad_cfg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_pos_ctr.md
FRAME_POS_CTR -- requirements
Module: frame_pos_ctr

Interface
REQ-001: Parameter MAP_MODE, default 1, 0 = demap (receive) counting and 1 = map (transmit) counting.
REQ-002: Parameter ROWS, default 4, rows per frame.
REQ-003: Parameter COLS, default 1041, columns per row (0..COLS-1).
REQ-004: Parameter OH_COLS, default 16, leading overhead columns per row (0..OH_COLS-1).
REQ-005: Parameter MF_W, default 8, multiframe counter width.
REQ-006: i_clk  input  1  clock; all state updates on the rising edge.
REQ-007: i_rst  input  1  reset, synchronous, active-high.
REQ-008: i_enable  input  1  global advance enable.
REQ-009: i_valid  input  1  data beat present this cycle.
REQ-010: i_sync  input  1  demap only; the current beat is row 0, column 0 (frame alignment pulse).
REQ-011: o_row  output  clog2(ROWS)  current row.
REQ-012: o_col  output  clog2(COLS)  current column.
REQ-013: o_mf  output  MF_W  multiframe count.
REQ-014: o_adv  output  1  position advances at the next edge.
REQ-015: o_ready  output  1  map only; client payload beat accepted this cycle.
REQ-016: o_oh, o_sof, o_eof, o_sync_err  output  1 each  overhead column; row 0/col 0; row ROWS-1/col COLS-1; alignment mismatch.

Function
REQ-017: Position SHALL be registered (row, col, mf); o_oh, o_sof, o_eof, o_adv and o_ready SHALL be combinational decodes of the current registers and inputs.
REQ-018: Demap mode: o_adv = i_enable & i_valid.
REQ-019: Map mode: o_adv = i_enable & (o_oh | i_valid), so overhead columns advance without client data.
REQ-020: Map mode: o_ready = i_enable & ~o_oh; demap mode: o_ready = 0.
REQ-021: On advance, col SHALL increment; at col COLS-1 it SHALL wrap to 0 and row SHALL increment.
REQ-022: At the last position (ROWS-1, COLS-1), an advance SHALL set row and col to 0 and increment o_mf modulo 2^MF_W.
REQ-023: With o_adv = 0, all state SHALL hold, including at column COLS-1.
REQ-024: Demap mode, i_sync & i_valid & i_enable: the next position SHALL be (0, 1), overriding the normal advance; o_mf SHALL be unchanged.
REQ-025: o_sync_err SHALL be a one-cycle registered pulse, asserted the cycle after an accepted i_sync seen while the position was not (0, 0).
REQ-026: i_sync SHALL be ignored in map mode, or when i_valid or i_enable is low.
REQ-027: With MAP_MODE not 0 or 1, or OH_COLS >= COLS, or ROWS < 2, all outputs SHALL be tied to 0.
REQ-028: All arithmetic SHALL be unsigned, with no overflow beyond the declared widths.

Reset
REQ-029: i_rst SHALL take priority over all other inputs.
REQ-030: On reset, row = 0, col = 0, mf = 0 and o_sync_err = 0; hence o_sof = 1 and o_oh = 1 after reset.
REQ-031: Reset mid-frame SHALL discard the current position with no residual pulse.

Verification
REQ-032: Reset, then idle -> o_row = 0, o_col = 0, o_mf = 0, o_sof = 1, o_oh = 1, o_sync_err = 0.
REQ-033: Demap, i_valid = i_enable = 1 for 4164 cycles -> o_eof high exactly at (3, 1040); return to (0, 0) with o_mf = 1; after 256 frames o_mf wraps to 0.
REQ-034: Map, i_enable = 1, i_valid = 0 from (0, 0) -> columns 0..15 advance with o_ready = 0; stall at col 16 with o_ready = 1 and o_adv = 0; i_valid = 1 resumes advancing.
REQ-035: Demap at (2, 500) with i_sync = i_valid = i_enable = 1 -> next cycle (0, 1) and o_sync_err = 1 for exactly one cycle; i_sync at (0, 0) -> no error.
REQ-036: i_enable = 0 at (1, 1040) with i_valid = 1 -> position holds; reset asserted at (1, 700) -> (0, 0) next cycle, o_mf = 0.
